// File: rtl/player_hit_ctrl.sv
// ---------------------------------------------------------------------------
// player_hit_ctrl
//   Receiving end of the enemy shot path. Detects an enemy bullet overlapping
//   the player tank on frame ticks and sequences the tank through explosion,
//   respawn with temporary invulnerability, and final game over. All timing
//   is counted in refresh_tick frames.
//
// Ports
//   clk_50MHz      in   system clock
//   reset          in   asynchronous active-low reset
//   refresh_tick   in   one-cycle frame strobe
//   x_enemy_bullet in   [9:0] enemy bullet left edge
//   y_enemy_bullet in   [9:0] enemy bullet top edge
//   x_tank         in   [9:0] player tank left edge
//   y_tank         in   [9:0] player tank top edge
//   hit            out  impact flag, held until after the next frame tick
//   tank_detroyed  out  high while exploding and in game over
//   tank_invuln    out  high while invulnerable after a respawn
//   respawn        out  one-cycle pulse returning the tank to its start
//   lives          out  [2:0] remaining lives
//   game_over      out  high once the last life has been lost
// ---------------------------------------------------------------------------
module player_hit_ctrl #(
  parameter int LIVES         = 3,
  parameter int BOOM_FRAMES   = 30,
  parameter int INVULN_FRAMES = 120,
  parameter int TANK_SIZE     = 32,
  parameter int BULLET_SIZE   = 4
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic [9:0] x_enemy_bullet,
  input  logic [9:0] y_enemy_bullet,
  input  logic [9:0] x_tank,
  input  logic [9:0] y_tank,
  output logic       hit,
  output logic       tank_detroyed,
  output logic       tank_invuln,
  output logic       respawn,
  output logic [2:0] lives,
  output logic       game_over
);

  // One shared frame counter serves both the explosion and the
  // invulnerability phases; it only ever counts up to the last frame index.
  localparam int MAX_FRAMES = (BOOM_FRAMES > INVULN_FRAMES) ? BOOM_FRAMES : INVULN_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  localparam logic [CNT_W-1:0] BOOM_LAST   = CNT_W'(BOOM_FRAMES - 1);
  localparam logic [CNT_W-1:0] INVULN_LAST = CNT_W'(INVULN_FRAMES - 1);
  localparam logic [2:0]       LIVES_INIT  = 3'(LIVES);
  localparam logic [10:0]      TANK_EXT    = 11'(TANK_SIZE);
  localparam logic [10:0]      BULLET_EXT  = 11'(BULLET_SIZE);

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    BOOM      = 2'd1,
    RESPAWN   = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] frame_cnt;

  // Zero-extend to 11 bits so edge + size never wraps near the right or
  // bottom of the 10-bit coordinate space.
  logic [10:0] xb, yb, xt, yt;
  logic        ov;

  assign xb = {1'b0, x_enemy_bullet};
  assign yb = {1'b0, y_enemy_bullet};
  assign xt = {1'b0, x_tank};
  assign yt = {1'b0, y_tank};

  assign ov = (xb < xt + TANK_EXT) && (xb + BULLET_EXT > xt) &&
              (yb < yt + TANK_EXT) && (yb + BULLET_EXT > yt);

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state         <= ALIVE;
      frame_cnt     <= '0;
      lives         <= LIVES_INIT;
      hit           <= 1'b0;
      tank_detroyed <= 1'b0;
      tank_invuln   <= 1'b0;
      respawn       <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      respawn <= 1'b0;

      // The bullet logic only looks at hit on frame ticks, so hold it until
      // one tick has gone by after it rose. A fresh detection below takes
      // priority because it is assigned later in this block.
      if (hit && refresh_tick) begin
        hit <= 1'b0;
      end

      case (state)
        ALIVE: begin
          if (refresh_tick && ov) begin
            state         <= BOOM;
            frame_cnt     <= '0;
            lives         <= (lives != 3'd0) ? lives - 3'd1 : 3'd0;
            hit           <= 1'b1;
            tank_detroyed <= 1'b1;
          end
        end

        BOOM: begin
          if (refresh_tick) begin
            if (frame_cnt == BOOM_LAST) begin
              frame_cnt <= '0;
              if (lives == 3'd0) begin
                state     <= GAME_OVER;
                game_over <= 1'b1;
              end else begin
                state         <= RESPAWN;
                tank_detroyed <= 1'b0;
                tank_invuln   <= 1'b1;
                respawn       <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
        end

        RESPAWN: begin
          if (refresh_tick) begin
            if (frame_cnt == INVULN_LAST) begin
              state       <= ALIVE;
              frame_cnt   <= '0;
              tank_invuln <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
        end

        GAME_OVER: begin
          // Terminal until reset.
          tank_detroyed <= 1'b1;
          game_over     <= 1'b1;
        end

        default: begin
          state <= ALIVE;
        end
      endcase
    end
  end

endmodule
